// File: rtl/jtcontra_pkg.sv
// Shared definitions for the Contra-family video path: palette bit fields,
// pixel transparency code and the colour mixer pipeline depth.
package jtcontra_pkg;

  // 15-bit palette entry layout (bit 15 carries no colour)
  localparam int PAL_R_LSB = 0;
  localparam int PAL_G_LSB = 5;
  localparam int PAL_B_LSB = 10;
  localparam int PAL_CHW   = 5;

  // Low nibble value that marks a pixel as transparent
  localparam logic [3:0] TRANSP_MASK = 4'h0;

  // Pixel-enable stages between gfx_pxl and RGB (also the blanking delay)
  localparam int COLMIX_LAT = 3;

  typedef struct packed {
    logic [PAL_CHW-1:0] b;
    logic [PAL_CHW-1:0] g;
    logic [PAL_CHW-1:0] r;
  } pal_rgb_t;

  // Split the colour bits of a palette entry into its three channels
  function automatic pal_rgb_t pal_unpack(input logic [14:0] entry);
    pal_rgb_t c;
    c.r = entry[PAL_R_LSB +: PAL_CHW];
    c.g = entry[PAL_G_LSB +: PAL_CHW];
    c.b = entry[PAL_B_LSB +: PAL_CHW];
    return c;
  endfunction

  // Half-brightness for shadowed pixels
  function automatic logic [PAL_CHW-1:0] chan_shade(input logic [PAL_CHW-1:0] c,
                                                    input logic             en);
    return en ? (c >> 1) : c;
  endfunction

endpackage

// File: rtl/jtcontra_colmix_pal.sv
// Palette storage for the colour mixer: two byte-wide banks (even/odd byte
// address) so the video side fetches a full 16-bit entry in one access while
// the CPU sees a plain byte-addressed memory. Both ports read-before-write.
module jtcontra_colmix_pal
  import jtcontra_pkg::*;
#(
  parameter int PXLW = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  // CPU byte port
  input  logic            cpu_we,
  input  logic [PXLW:0]   cpu_addr,
  input  logic [7:0]      cpu_din,
  output logic [7:0]      cpu_dout,
  // video entry port
  input  logic            vid_cen,
  input  logic [PXLW-1:0] vid_addr,
  output logic [15:0]     vid_data
);

  localparam int DEPTH = 1 << PXLW;

  logic cpu_sel_q, cpu_sel_d;

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_bank
    logic [7:0] mem [DEPTH];
    logic [7:0] cpu_rd_q;
    logic [7:0] vid_rd_q;
    logic       bank_we;

    assign bank_we = cpu_we && (cpu_addr[0] == 1'(gi));

    // CPU write into this bank; contents survive reset
    always_ff @(posedge clk) begin
      if (bank_we) mem[cpu_addr[PXLW:1]] <= cpu_din;
    end

    // CPU read register, every clk, returns pre-write data on a collision
    always_ff @(posedge clk) begin
      if (!rst_n) cpu_rd_q <= '0;
      else        cpu_rd_q <= mem[cpu_addr[PXLW:1]];
    end

    // Video read register, advances with the pixel enable
    always_ff @(posedge clk) begin
      if (!rst_n)       vid_rd_q <= '0;
      else if (vid_cen) vid_rd_q <= mem[vid_addr];
    end
  end

  // Remember which bank the CPU addressed so the output mux lines up
  always_comb begin
    cpu_sel_d = cpu_addr[0];
  end

  // Byte-select register for the CPU read mux
  always_ff @(posedge clk) begin
    if (!rst_n) cpu_sel_q <= 1'b0;
    else        cpu_sel_q <= cpu_sel_d;
  end

  assign cpu_dout = cpu_sel_q ? g_bank[1].cpu_rd_q : g_bank[0].cpu_rd_q;
  assign vid_data = {g_bank[1].vid_rd_q, g_bank[0].vid_rd_q};

endmodule

// File: rtl/jtcontra_colmix_n.sv
// Multi-layer colour mixer: fixed-priority layer select, palette lookup and
// blanking. Three pixel-enable stages: S1 index select, S2 palette read,
// S3 colour register with blanking applied.
// Optional build macro: JTCONTRA_SHADOW_EN (half-brightness shadow pixels).
// Layer pixels must be at least 4 bits wide (PXLW >= 4).
module jtcontra_colmix_n
  import jtcontra_pkg::*;
#(
  parameter int LAYERS = 2,
  parameter int PXLW   = 7,
  parameter int COLW   = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pxl_cen,
  input  logic                   cpu_cen,
  input  logic                   LHBL,
  input  logic                   LVBL,
  output logic                   LHBL_dly,
  output logic                   LVBL_dly,
  input  logic                   pal_cs,
  input  logic                   cpu_rnw,
  input  logic [PXLW:0]          cpu_addr,
  input  logic [7:0]             cpu_dout,
  output logic [7:0]             pal_dout,
  input  logic [LAYERS*PXLW-1:0] gfx_pxl,
  input  logic                   shadow,
  input  logic [LAYERS-1:0]      gfx_en,
  output logic [COLW-1:0]        red,
  output logic [COLW-1:0]        green,
  output logic [COLW-1:0]        blue
);

  // ---------------------------------------------------------------------------
  // Layer split and transparency
  // ---------------------------------------------------------------------------
  logic [PXLW-1:0]   layer_pxl [LAYERS];
  logic [LAYERS-1:0] opaque;

  genvar gi;
  for (gi = 0; gi < LAYERS; gi++) begin : g_layer
    assign layer_pxl[gi] = gfx_pxl[gi*PXLW +: PXLW];
    assign opaque[gi]    = gfx_en[gi] && (layer_pxl[gi][3:0] != TRANSP_MASK);
  end

  logic [PXLW-1:0] sel_idx;
  logic            sel_bd;

  // Lowest-index opaque layer wins; otherwise the top layer is the backdrop
  always_comb begin
    sel_idx = gfx_en[LAYERS-1] ? layer_pxl[LAYERS-1] : '0;
    sel_bd  = 1'b1;
    for (int i = LAYERS - 1; i >= 0; i--) begin
      if (opaque[i]) begin
        sel_idx = layer_pxl[i];
        sel_bd  = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S1: selected palette index
  // ---------------------------------------------------------------------------
  logic [PXLW-1:0] s1_idx_q, s1_idx_d;

  // Hold the index between pixel enables
  always_comb begin
    s1_idx_d = s1_idx_q;
    if (pxl_cen) s1_idx_d = sel_idx;
  end

  // S1 index register
  always_ff @(posedge clk) begin
    if (!rst_n) s1_idx_q <= '0;
    else        s1_idx_q <= s1_idx_d;
  end

  // ---------------------------------------------------------------------------
  // Shadow tracking (only kept when the feature is built in)
  // ---------------------------------------------------------------------------
  logic s2_shade;

`ifdef JTCONTRA_SHADOW_EN
  logic s1_shadow_q, s1_shadow_d;
  logic s1_bd_q,     s1_bd_d;
  logic s2_shade_q,  s2_shade_d;

  // Carry the shadow flag alongside the index; backdrop pixels are never shaded
  always_comb begin
    s1_shadow_d = s1_shadow_q;
    s1_bd_d     = s1_bd_q;
    s2_shade_d  = s2_shade_q;
    if (pxl_cen) begin
      s1_shadow_d = shadow;
      s1_bd_d     = sel_bd;
      s2_shade_d  = s1_shadow_q & ~s1_bd_q;
    end
  end

  // Shadow pipeline registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_shadow_q <= 1'b0;
      s1_bd_q     <= 1'b0;
      s2_shade_q  <= 1'b0;
    end else begin
      s1_shadow_q <= s1_shadow_d;
      s1_bd_q     <= s1_bd_d;
      s2_shade_q  <= s2_shade_d;
    end
  end

  assign s2_shade = s2_shade_q;
`else
  logic [1:0] unused_shade;
  assign s2_shade     = 1'b0;
  assign unused_shade = {shadow, sel_bd};
`endif

  // ---------------------------------------------------------------------------
  // S2: palette (registered read inside the palette block)
  // ---------------------------------------------------------------------------
  logic        pal_we;
  logic [15:0] pal_vid;

  assign pal_we = pal_cs & ~cpu_rnw & cpu_cen;

  jtcontra_colmix_pal #(
    .PXLW (PXLW)
  ) u_pal (
    .clk      (clk),
    .rst_n    (rst_n),
    .cpu_we   (pal_we),
    .cpu_addr (cpu_addr),
    .cpu_din  (cpu_dout),
    .cpu_dout (pal_dout),
    .vid_cen  (pxl_cen),
    .vid_addr (s1_idx_q),
    .vid_data (pal_vid)
  );

  // ---------------------------------------------------------------------------
  // Blanking delay, same depth as the pixel path
  // ---------------------------------------------------------------------------
  logic [COLMIX_LAT-1:0] lhbl_sr_q, lhbl_sr_d;
  logic [COLMIX_LAT-1:0] lvbl_sr_q, lvbl_sr_d;

  // Shift the blanking inputs once per pixel
  always_comb begin
    lhbl_sr_d = lhbl_sr_q;
    lvbl_sr_d = lvbl_sr_q;
    if (pxl_cen) begin
      lhbl_sr_d = {lhbl_sr_q[COLMIX_LAT-2:0], LHBL};
      lvbl_sr_d = {lvbl_sr_q[COLMIX_LAT-2:0], LVBL};
    end
  end

  // Blanking shift registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lhbl_sr_q <= '0;
      lvbl_sr_q <= '0;
    end else begin
      lhbl_sr_q <= lhbl_sr_d;
      lvbl_sr_q <= lvbl_sr_d;
    end
  end

  assign LHBL_dly = lhbl_sr_q[COLMIX_LAT-1];
  assign LVBL_dly = lvbl_sr_q[COLMIX_LAT-1];

  // ---------------------------------------------------------------------------
  // S3: colour output
  // ---------------------------------------------------------------------------
  pal_rgb_t           entry;
  logic [PAL_CHW-1:0] r5, g5, b5;
  logic               rgb_on;
  logic [COLW-1:0]    red_q, red_d;
  logic [COLW-1:0]    green_q, green_d;
  logic [COLW-1:0]    blue_q, blue_d;
  logic [15:0]        unused_col;

  // Decode the entry, shade, truncate to COLW MSBs and blank; the blanking
  // bit used is the one that becomes LHBL_dly/LVBL_dly on the same edge
  always_comb begin
    entry   = pal_unpack(pal_vid[14:0]);
    r5      = chan_shade(entry.r, s2_shade);
    g5      = chan_shade(entry.g, s2_shade);
    b5      = chan_shade(entry.b, s2_shade);
    rgb_on  = lhbl_sr_q[COLMIX_LAT-2] & lvbl_sr_q[COLMIX_LAT-2];
    red_d   = red_q;
    green_d = green_q;
    blue_d  = blue_q;
    if (pxl_cen) begin
      red_d   = rgb_on ? r5[PAL_CHW-1 -: COLW] : '0;
      green_d = rgb_on ? g5[PAL_CHW-1 -: COLW] : '0;
      blue_d  = rgb_on ? b5[PAL_CHW-1 -: COLW] : '0;
    end
  end

  // Colour output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else begin
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
    end
  end

  // Bit 15 of the entry and the channel LSBs dropped for COLW=4 are unused
  assign unused_col = {pal_vid[15], r5, g5, b5};

  assign red   = red_q;
  assign green = green_q;
  assign blue  = blue_q;

endmodule
